tvip_mem_arb: RTL and testbench
===============================

Name: tvip_mem_arb

Overview:
- Three-channel arbiter sharing one memory command/response port (we/re/waddr/raddr/wdata/wb in, rvld/rdout out) between independent requesters.
- Round-robin grant per cycle; one command issued to memory per cycle.
- In-order read responses are routed back to the issuing channel through a channel-ID tag FIFO.
- Sits between the per-channel traffic sources and the memory model/controller port in the 3-channel environment.

Parameters:
- NUM_CH, 3, number of requesting channels
- ADDR_W, 28, command address width (row 15 + bank 3 + col 10)
- DATA_W, 256, data width (DQ 32 x burst 8)
- BE_W, DATA_W/8, byte-enable width
- MAX_RD_OUT, 8, maximum outstanding reads; tag FIFO depth, power of two

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- ch_valid  in  NUM_CH  per-channel command valid
- ch_ready  out  NUM_CH  per-channel command accepted (grant)
- ch_write  in  NUM_CH  1 = write, 0 = read
- ch_addr  in  NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NUM_CH*DATA_W  per-channel write data
- ch_wb  in  NUM_CH*BE_W  per-channel byte enables
- ch_rvld  out  NUM_CH  read-data valid, one-hot per returned beat
- ch_rdata  out  DATA_W  read data, shared by all channels, qualified by ch_rvld
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_waddr  out  ADDR_W  write address
- mem_raddr  out  ADDR_W  read address
- mem_wdata  out  DATA_W  write data
- mem_wb  out  BE_W  write byte enables
- mem_rvld  in  1  memory read data valid (responses in issue order)
- mem_rdout  in  DATA_W  memory read data
- rd_outstanding  out  $clog2(MAX_RD_OUT+1)  current outstanding read count
- err_unexp_rvld  out  1  sticky: mem_rvld received with no outstanding read

Behaviour:
- Reset:
  - All outputs 0.
  - RR pointer = 0.
  - Tag FIFO empty.
  - In-flight reads are discarded; rvld arriving after reset sets err_unexp_rvld.
- Eligibility:
  - Channel i is eligible when ch_valid[i] is set and (ch_write[i] or rd_outstanding < MAX_RD_OUT).
  - rd_outstanding is the registered value; a same-cycle pop does not free a slot.
- Grant:
  - Combinational.
  - First eligible channel searching from the RR pointer upward, wrapping.
  - ch_ready is one-hot or zero.
  - Handshake happens on ch_valid & ch_ready.
- Pointer: after a grant to channel g, the pointer becomes (g+1) mod NUM_CH. Otherwise it is unchanged.
- Command issue (registered, 1-cycle latency):
  - Cycle after a write grant: mem_we=1 for exactly one cycle, with waddr/wdata/wb of the granted channel.
  - Cycle after a read grant: mem_re=1 for exactly one cycle, with raddr.
  - mem_we and mem_re are never both 1.
  - Address/data outputs hold their last value when strobes are low.
- Tag FIFO:
  - Push the granted channel ID on a read grant.
  - Pop on mem_rvld.
  - Simultaneous push and pop: count unchanged, both performed.
  - Pointers wrap modulo MAX_RD_OUT.
- Response (registered, 1-cycle latency):
  - Cycle after mem_rvld, ch_rvld[head ID]=1 and ch_rdata=mem_rdout.
  - ch_rdata holds its value otherwise.
- Unexpected rvld: mem_rvld while the FIFO is empty (count 0, no same-cycle push counted) sets err_unexp_rvld, which stays set until reset. No pop, no ch_rvld.
- Requesters may drop ch_valid without a grant; no lock-out.
- Starvation bound: a continuously eligible channel is granted within NUM_CH cycles.

Decomposition:
- Package tvip_mem_arb_pkg:
  - ch_id_t (logic [$clog2(NUM_CH)-1:0])
  - default width constants ADDR_W/DATA_W/BE_W
  - MAX_RD_OUT default
- Sub-module tvip_mem_rr_arb: NUM_CH-wide request vector in, one-hot grant out, registered pointer, with an advance-on-grant input.
- Tag FIFO and issue/response registers are inline in tvip_mem_arb.

Test Plan:
- Single write: ch1 write, addr 0x0001234, wdata all-0xA5, wb all-ones -> ch_ready[1] same cycle; next cycle mem_we=1, mem_waddr=0x0001234, mem_wdata all-0xA5; ch_rvld stays 0.
- Round-robin: all three channels hold valid writes for 6 cycles from reset -> grant order 0,1,2,0,1,2; each mem_we carries the matching channel's addr.
- Read routing: ch2 reads 0x10, then ch0 reads 0x20; memory returns D2 then D0 3 cycles after each mem_re -> ch_rvld[2] with D2, then ch_rvld[0] with D0; rd_outstanding goes 1,2,1,0.
- Outstanding limit: ch0 issues 8 reads with no rvld -> rd_outstanding=8; a 9th ch0 read gets no ready while a ch1 write is still granted. One mem_rvld -> the ch0 read is granted the cycle after the count drops to 7.
- Simultaneous push/pop at count 3: read grant plus mem_rvld in the same cycle -> count stays 3, correct head ID returned.
- Error/reset: mem_rvld with FIFO empty -> err_unexp_rvld=1 sticky. Then areset_n low mid-traffic with 2 reads outstanding -> all outputs 0 immediately, rd_outstanding=0, err cleared.

Source files
------------

// File: rtl/tvip_mem_arb_pkg.sv
// Shared types and default sizing for the three-channel memory arbiter.
// Sizes follow the memory port: 28-bit row/bank/col address, 256-bit DQ burst.
package tvip_mem_arb_pkg;

   localparam int NUM_CH_DEF     = 3;
   localparam int ADDR_W_DEF     = 28;
   localparam int DATA_W_DEF     = 256;
   localparam int BE_W_DEF       = DATA_W_DEF / 8;
   localparam int MAX_RD_OUT_DEF = 8;

   localparam int CH_ID_W = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

   typedef logic [CH_ID_W-1:0] ch_id_t;

   // Round-robin successor of a channel id among n channels.
   function automatic ch_id_t rr_next(input ch_id_t id, input int n);
      return (int'(id) >= n - 1) ? '0 : ch_id_t'(int'(id) + 1);
   endfunction

endpackage

// File: rtl/tvip_mem_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a registered
// pointer; pointer moves past the winner when adv is high. No internal backpressure.
module tvip_mem_rr_arb
   import tvip_mem_arb_pkg::*;
#(
   parameter int N = NUM_CH_DEF
)(
   input  logic         aclk,
   input  logic         areset_n,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] gnt,
   output ch_id_t       gnt_id
);

   ch_id_t ptr;
   logic   found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = ch_id_t'(idx);
         end
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         ptr <= '0;
      end else if (adv && found) begin
         ptr <= rr_next(gnt_id, N);
      end
   end

endmodule

// File: rtl/tvip_mem_arb.sv
// Shares one memory port among NUM_CH requesters; grant is combinational, command and
// response are registered (1 cycle each). Reads stall via ch_ready once MAX_RD_OUT are in flight.
module tvip_mem_arb
   import tvip_mem_arb_pkg::*;
#(
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int BE_W       = DATA_W / 8,
   parameter int MAX_RD_OUT = MAX_RD_OUT_DEF
)(
   input  logic                          aclk,
   input  logic                          areset_n,
   input  logic [NUM_CH-1:0]             ch_valid,
   output logic [NUM_CH-1:0]             ch_ready,
   input  logic [NUM_CH-1:0]             ch_write,
   input  logic [NUM_CH*ADDR_W-1:0]      ch_addr,
   input  logic [NUM_CH*DATA_W-1:0]      ch_wdata,
   input  logic [NUM_CH*BE_W-1:0]        ch_wb,
   output logic [NUM_CH-1:0]             ch_rvld,
   output logic [DATA_W-1:0]             ch_rdata,
   output logic                          mem_we,
   output logic                          mem_re,
   output logic [ADDR_W-1:0]             mem_waddr,
   output logic [ADDR_W-1:0]             mem_raddr,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic [BE_W-1:0]               mem_wb,
   input  logic                          mem_rvld,
   input  logic [DATA_W-1:0]             mem_rdout,
   output logic [$clog2(MAX_RD_OUT+1)-1:0] rd_outstanding,
   output logic                          err_unexp_rvld
);

   localparam int CW = $clog2(MAX_RD_OUT + 1);
   localparam int PW = $clog2(MAX_RD_OUT);

   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] gnt;
   ch_id_t            gid;
   logic              hs;
   logic              gwr;
   logic              push;
   logic              pop;
   logic              unexp;
   logic [CW-1:0]     rd_cnt;
   logic [PW-1:0]     wp;
   logic [PW-1:0]     rp;
   ch_id_t            tag_mem [MAX_RD_OUT];

   // Registered count only: a pop in this cycle does not open a read slot until next cycle.
   assign elig = ch_valid & (ch_write | {NUM_CH{rd_cnt < CW'(MAX_RD_OUT)}});

   tvip_mem_rr_arb #(.N(NUM_CH)) u_rr (
      .aclk     (aclk),
      .areset_n (areset_n),
      .req      (elig),
      .adv      (hs),
      .gnt      (gnt),
      .gnt_id   (gid)
   );

   assign ch_ready = gnt & {NUM_CH{areset_n}};
   assign hs       = |ch_ready;
   assign gwr      = ch_write[gid];

   assign push  = hs & ~gwr;
   assign pop   = mem_rvld & (rd_cnt != '0);
   assign unexp = mem_rvld & (rd_cnt == '0);

   assign rd_outstanding = rd_cnt;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_waddr <= '0;
         mem_raddr <= '0;
         mem_wdata <= '0;
         mem_wb    <= '0;
      end else begin
         mem_we <= hs & gwr;
         mem_re <= hs & ~gwr;
         if (hs && gwr) begin
            mem_waddr <= ch_addr[int'(gid)*ADDR_W +: ADDR_W];
            mem_wdata <= ch_wdata[int'(gid)*DATA_W +: DATA_W];
            mem_wb    <= ch_wb[int'(gid)*BE_W +: BE_W];
         end
         if (hs && !gwr) begin
            mem_raddr <= ch_addr[int'(gid)*ADDR_W +: ADDR_W];
         end
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         rd_cnt <= '0;
         wp     <= '0;
         rp     <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   rd_cnt <= rd_cnt + 1'b1;
            2'b01:   rd_cnt <= rd_cnt - 1'b1;
            default: rd_cnt <= rd_cnt;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (push) tag_mem[wp] <= gid;
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         ch_rvld        <= '0;
         ch_rdata       <= '0;
         err_unexp_rvld <= 1'b0;
      end else begin
         ch_rvld <= pop ? (NUM_CH'(1) << tag_mem[rp]) : '0;
         if (pop) ch_rdata <= mem_rdout;
         err_unexp_rvld <= err_unexp_rvld | unexp;
      end
   end

endmodule

// File: tb/tb_tvip_mem_arb.sv
// Bench for tvip_mem_arb: directed scenarios then random traffic, every cycle compared
// against a transaction-level model (grant search, tag queue, expected port values).
module tb_tvip_mem_arb;

   localparam int NCH  = 3;
   localparam int AW   = 28;
   localparam int DW   = 256;
   localparam int BW   = 32;
   localparam int MAXR = 8;
   localparam int CW   = 4;

   logic              aclk = 1'b0;
   logic              areset_n;
   logic [NCH-1:0]    ch_valid, ch_ready, ch_write, ch_rvld;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*DW-1:0] ch_wdata;
   logic [NCH*BW-1:0] ch_wb;
   logic [DW-1:0]     ch_rdata;
   logic              mem_we, mem_re, mem_rvld;
   logic [AW-1:0]     mem_waddr, mem_raddr;
   logic [DW-1:0]     mem_wdata, mem_rdout;
   logic [BW-1:0]     mem_wb;
   logic [CW-1:0]     rd_outstanding;
   logic              err_unexp_rvld;

   always #5 aclk = ~aclk;

   tvip_mem_arb dut (
      .aclk(aclk), .areset_n(areset_n),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_write(ch_write),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wb(ch_wb),
      .ch_rvld(ch_rvld), .ch_rdata(ch_rdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
      .mem_wdata(mem_wdata), .mem_wb(mem_wb), .mem_rvld(mem_rvld), .mem_rdout(mem_rdout),
      .rd_outstanding(rd_outstanding), .err_unexp_rvld(err_unexp_rvld)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: what the ports must show after the most recent edge.
   int             m_ptr;
   int             m_tags[$];
   bit             m_err;
   logic           m_we, m_re;
   logic [AW-1:0]  m_waddr, m_raddr;
   logic [DW-1:0]  m_wdata, m_rdata;
   logic [BW-1:0]  m_wb;
   logic [NCH-1:0] m_rvld;

   int             pend_due[$];
   logic [DW-1:0]  pend_dat[$];
   int             cyc = 0;
   int             last_due = 0;
   bit             auto_mem = 0;
   int             dly_lo = 1, dly_hi = 4;
   logic [NCH-1:0] rvq[$];

   function automatic logic [DW-1:0] rand256();
      logic [DW-1:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic int model_grant();
      for (int k = 0; k < NCH; k++) begin
         int i;
         i = (m_ptr + k) % NCH;
         if (ch_valid[i] && (ch_write[i] || m_tags.size() < MAXR)) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_tags.delete(); m_err = 0;
      m_we = 0; m_re = 0; m_waddr = '0; m_raddr = '0;
      m_wdata = '0; m_rdata = '0; m_wb = '0; m_rvld = '0;
      pend_due.delete(); pend_dat.delete(); last_due = 0;
   endtask

   task automatic model_step(input int g);
      m_we = 0; m_re = 0; m_rvld = '0;
      if (mem_rvld) begin
         if (m_tags.size() > 0) begin
            int t;
            t = m_tags.pop_front();
            m_rvld  = NCH'(1) << t;
            m_rdata = mem_rdout;
         end else begin
            m_err = 1;
         end
      end
      if (g >= 0) begin
         if (ch_write[g]) begin
            m_we = 1;
            m_waddr = ch_addr[g*AW +: AW];
            m_wdata = ch_wdata[g*DW +: DW];
            m_wb    = ch_wb[g*BW +: BW];
         end else begin
            m_re = 1;
            m_raddr = ch_addr[g*AW +: AW];
            m_tags.push_back(g);
         end
         m_ptr = (g + 1) % NCH;
      end
   endtask

   task automatic check_regs();
      chk("mem_we", mem_we, m_we);
      chk("mem_re", mem_re, m_re);
      chk("mem_waddr", mem_waddr, m_waddr);
      chk("mem_raddr", mem_raddr, m_raddr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wb", mem_wb, m_wb);
      chk("ch_rvld", ch_rvld, m_rvld);
      chk("ch_rdata", ch_rdata, m_rdata);
      chk("rd_outstanding", rd_outstanding, m_tags.size());
      chk("err_unexp_rvld", err_unexp_rvld, m_err);
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_ready"}, ch_ready, 0);
      chk({tag, "_rvld"}, ch_rvld, 0);
      chk({tag, "_rdata"}, ch_rdata, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_re"}, mem_re, 0);
      chk({tag, "_waddr"}, mem_waddr, 0);
      chk({tag, "_raddr"}, mem_raddr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_wb"}, mem_wb, 0);
      chk({tag, "_rdout"}, rd_outstanding, 0);
      chk({tag, "_err"}, err_unexp_rvld, 0);
   endtask

   // Inputs are set at the falling edge before calling; one call = one clock.
   task automatic tick();
      int g;
      if (auto_mem) begin
         if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_rvld  = 1'b1;
            mem_rdout = pend_dat.pop_front();
            void'(pend_due.pop_front());
         end else begin
            mem_rvld = 1'b0;
         end
      end
      #1;
      g = model_grant();
      chk("ch_ready", ch_ready, (g >= 0) ? (NCH'(1) << g) : NCH'(0));
      @(posedge aclk);
      model_step(g);
      @(negedge aclk);
      cyc++;
      check_regs();
      if (ch_rvld != '0) rvq.push_back(ch_rvld);
      if (auto_mem && m_re) begin
         int due;
         due = cyc + $urandom_range(dly_lo, dly_hi);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_due.push_back(due);
         pend_dat.push_back(rand256());
      end
   endtask

   task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
      ch_write[i] = wr;
      ch_addr[i*AW +: AW]  = a;
      ch_wdata[i*DW +: DW] = d;
      ch_wb[i*BW +: BW]    = b;
   endtask

   task automatic do_reset();
      @(negedge aclk);
      areset_n = 1'b0;
      ch_valid = '0;
      mem_rvld = 1'b0;
      #1;
      zero_check("rst");
      model_reset();
      @(negedge aclk);
      areset_n = 1'b1;
   endtask

   initial begin
      areset_n = 1'b0;
      ch_valid = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0; ch_wb = '0;
      mem_rvld = 1'b0; mem_rdout = '0;
      model_reset();
      repeat (2) @(negedge aclk);
      zero_check("por");
      areset_n = 1'b1;

      // Single write from channel 1
      set_cmd(1, 1'b1, 28'h0001234, {32{8'hA5}}, '1);
      ch_valid = 3'b010;
      tick();
      chk("t1_we", mem_we, 1);
      chk("t1_waddr", mem_waddr, 28'h0001234);
      chk("t1_wdata", mem_wdata, {32{8'hA5}});
      chk("t1_rvld", ch_rvld, 0);
      ch_valid = '0;
      tick();
      chk("t1_we_once", mem_we, 0);

      // Round-robin among three persistent writers
      do_reset();
      for (int i = 0; i < NCH; i++) set_cmd(i, 1'b1, AW'(28'h100 + i), rand256(), BW'($urandom));
      ch_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr_waddr", mem_waddr, 28'h100 + (k % NCH));
      end
      ch_valid = '0;
      tick();

      // Read routing through the tag FIFO, fixed 3-cycle memory latency
      do_reset();
      rvq.delete();
      auto_mem = 1; dly_lo = 3; dly_hi = 3;
      set_cmd(2, 1'b0, 28'h10, '0, '0);
      ch_valid = 3'b100;
      tick();
      set_cmd(0, 1'b0, 28'h20, '0, '0);
      ch_valid = 3'b001;
      tick();
      ch_valid = '0;
      repeat (8) tick();
      chk("t3_nresp", rvq.size(), 2);
      chk("t3_first", rvq[0], 3'b100);
      chk("t3_second", rvq[1], 3'b001);
      auto_mem = 0;

      // Outstanding-read limit
      do_reset();
      set_cmd(0, 1'b0, 28'h300, '0, '0);
      ch_valid = 3'b001;
      repeat (MAXR) tick();
      chk("t4_cnt8", rd_outstanding, MAXR);
      set_cmd(1, 1'b1, 28'h301, rand256(), '1);
      ch_valid = 3'b011;
      #1;
      chk("t4_blocked", ch_ready, 3'b010);
      tick();
      ch_valid  = 3'b001;
      mem_rvld  = 1'b1;
      mem_rdout = rand256();
      #1;
      chk("t4_no_early", ch_ready, 3'b000);
      tick();
      mem_rvld = 1'b0;
      #1;
      chk("t4_after7", ch_ready, 3'b001);
      tick();
      ch_valid = '0;
      tick();

      // Simultaneous push and pop at count 3
      do_reset();
      set_cmd(0, 1'b0, 28'h400, '0, '0);
      ch_valid = 3'b001;
      repeat (3) tick();
      set_cmd(1, 1'b0, 28'h401, '0, '0);
      ch_valid  = 3'b010;
      mem_rvld  = 1'b1;
      mem_rdout = rand256();
      tick();
      chk("t5_cnt", rd_outstanding, 3);
      chk("t5_head", ch_rvld, 3'b001);
      mem_rvld = 1'b0;
      ch_valid = '0;
      tick();

      // Unexpected response, then reset with reads in flight
      do_reset();
      mem_rvld = 1'b1;
      tick();
      mem_rvld = 1'b0;
      chk("t6_err", err_unexp_rvld, 1);
      repeat (3) tick();
      chk("t6_sticky", err_unexp_rvld, 1);
      set_cmd(2, 1'b0, 28'h500, '0, '0);
      ch_valid = 3'b100;
      repeat (2) tick();
      chk("t6_cnt2", rd_outstanding, 2);
      #3;
      areset_n = 1'b0;
      #1;
      zero_check("t6_midrst");
      model_reset();
      ch_valid = '0;
      @(negedge aclk);
      areset_n = 1'b1;
      mem_rvld = 1'b1;
      tick();
      mem_rvld = 1'b0;
      chk("t6_stale_rvld", err_unexp_rvld, 1);

      // Random traffic
      do_reset();
      auto_mem = 1; dly_lo = 1; dly_hi = 12;
      repeat (1500) begin
         for (int i = 0; i < NCH; i++)
            set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom), rand256(), BW'($urandom));
         ch_valid = NCH'($urandom);
         tick();
      end
      ch_valid = '0;
      repeat (30) tick();
      chk("rand_drained", rd_outstanding, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
